muldiv_iter: RTL and testbench

Parametrised iterative signed multiply/divide unit for the multicycle CPU. It executes MULT and DIV one bit per clock and writes a double-width result into internal HI/LO registers. The control unit holds the instruction in a wait state on `busy` and steps on `done`. Divide-by-zero is reported so the control FSM can raise an exception through EPC.

---
 rtl/muldiv_iter.sv | 177 +++++++++++++++++
 tb/tb_muldiv_iter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative signed multiply/divide unit, one bit per clock.
//   WIDTH-bit two's complement operands a/b.
//   op = 0: signed multiply, {hi, lo} = a * b.
//   op = 1: signed divide, lo = a / b, hi = a % b (truncation toward zero).
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   start, op, a, b - request, operation select, operands (sampled when not busy)
//   hi, lo          - registered result (remainder/quotient or product halves)
//   busy            - high while an operation iterates (RUN and FIX)
//   done            - one-cycle pulse when hi/lo are valid or div_zero is set
//   div_zero        - one-cycle pulse with done when a divide had b == 0
module muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned DW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic             r_op;
    logic             r_neg;
    logic             r_a_neg;
    logic [WIDTH-1:0] r_mb;
    logic [DW-1:0]    r_acc;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;
    logic             r_dz;

    logic             w_accept;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_dz_nxt;
    logic             w_last;

    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_add;
    logic [WIDTH:0]   w_msum;
    logic [DW-1:0]    w_mul_nxt;
    logic [DW-1:0]    w_dshift;
    logic [WIDTH:0]   w_trial;
    logic [DW-1:0]    w_div_nxt;
    logic [DW-1:0]    w_prod;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done_nxt  = 1'b0;
        w_dz_nxt    = 1'b0;
        w_last      = (r_cnt == CW'(WIDTH - 1));
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (op && (b == '0)) begin
                        // Divide by zero skips the iterations entirely
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                        w_dz_nxt    = 1'b1;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                w_state_nxt = S_DONE;
                w_done_nxt  = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_FIX);
    end

    // Datapath: operand magnitudes, one iteration step, sign correction
    always_comb begin
        w_mag_a   = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
        w_mag_b   = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;

        // Shift-add: add multiplicand into the upper half when the lsb is set,
        // then shift right keeping the carry.
        w_add     = r_acc[0] ? r_mb : '0;
        w_msum    = {1'b0, r_acc[DW-1:WIDTH]} + {1'b0, w_add};
        w_mul_nxt = {w_msum, r_acc[WIDTH-1:1]};

        // Restoring division: acc = {remainder, dividend/quotient bits}
        w_dshift  = {r_acc[DW-2:0], 1'b0};
        w_trial   = {1'b0, w_dshift[DW-1:WIDTH]} - {1'b0, r_mb};
        w_div_nxt = w_trial[WIDTH] ? w_dshift
                                   : {w_trial[WIDTH-1:0], w_dshift[WIDTH-1:1], 1'b1};

        w_prod    = r_neg ? (~r_acc + DW'(1)) : r_acc;
        w_quo     = r_neg ? (~r_acc[WIDTH-1:0] + WIDTH'(1)) : r_acc[WIDTH-1:0];
        w_rem     = r_a_neg ? (~r_acc[DW-1:WIDTH] + WIDTH'(1)) : r_acc[DW-1:WIDTH];
    end

    // State, control outputs and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= 1'b0;
            r_neg   <= 1'b0;
            r_a_neg <= 1'b0;
            r_mb    <= '0;
            r_acc   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_dz    <= w_dz_nxt;
            if (w_accept) begin
                r_cnt   <= '0;
                r_op    <= op;
                r_neg   <= a[WIDTH-1] ^ b[WIDTH-1];
                r_a_neg <= a[WIDTH-1];
                r_mb    <= w_mag_b;
                r_acc   <= {{WIDTH{1'b0}}, w_mag_a};
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt + CW'(1);
                r_acc <= r_op ? w_div_nxt : w_mul_nxt;
            end else if (r_state == S_FIX) begin
                if (r_op) begin
                    r_hi <= w_rem;
                    r_lo <= w_quo;
                end else begin
                    r_hi <= w_prod[DW-1:WIDTH];
                    r_lo <= w_prod[WIDTH-1:0];
                end
            end
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_dz;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed testbench for muldiv_iter (WIDTH = 32).
module tb_muldiv_iter;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int checks = 0;
    int errors = 0;

    muldiv_iter #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request for a single edge (E0); returns at the negedge after E0
    task automatic launch(input logic o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = 32'hDEAD_BEEF;
        b     = 32'h0BAD_F00D;
    endtask

    // k = edges after E0 until done is seen; nb = cycles with busy high
    task automatic wait_done(output int k, output int nb);
        k  = 0;
        nb = 0;
        while (done !== 1'b1 && k < 200) begin
            if (busy === 1'b1) nb++;
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({hi, lo} !== 64'h0) begin
            errors++;
            $display("FAIL reset_hilo: got %h_%h expected 0", hi, lo);
        end
        checks++;
        if ({busy, done, div_zero} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: got busy/done/dz=%b expected 000", {busy, done, div_zero});
        end
        reset = 1'b0;
    endtask

    task automatic test_mult_basic();
        int k;
        int nb;
        launch(1'b0, 32'd7, 32'hFFFF_FFFD);
        wait_done(k, nb);
        checks++;
        if (k !== 33) begin
            errors++;
            $display("FAIL mult_latency: got %0d expected 33", k);
        end
        checks++;
        if (nb !== 33) begin
            errors++;
            $display("FAIL mult_busy_cycles: got %0d expected 33", nb);
        end
        checks++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            errors++;
            $display("FAIL mult_7x-3: got %h_%h expected ffffffff_ffffffeb", hi, lo);
        end
        checks++;
        if ({busy, div_zero} !== 2'b00) begin
            errors++;
            $display("FAIL mult_done_flags: got busy/dz=%b expected 00", {busy, div_zero});
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || {hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            errors++;
            $display("FAIL mult_after_done: got done=%b %h_%h expected done=0 ffffffff_ffffffeb",
                     done, hi, lo);
        end
    endtask

    task automatic test_mult_corners();
        int k;
        int nb;
        launch(1'b0, 32'h8000_0000, 32'h8000_0000);
        wait_done(k, nb);
        checks++;
        if ({hi, lo} !== 64'h4000_0000_0000_0000) begin
            errors++;
            $display("FAIL mult_minxmin: got %h_%h expected 40000000_00000000", hi, lo);
        end
        launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(k, nb);
        checks++;
        if ({hi, lo} !== 64'h0000_0000_0000_0001) begin
            errors++;
            $display("FAIL mult_m1xm1: got %h_%h expected 00000000_00000001", hi, lo);
        end
    endtask

    task automatic test_div();
        int k;
        int nb;
        launch(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done(k, nb);
        checks++;
        if (k !== 33) begin
            errors++;
            $display("FAIL div_latency: got %0d expected 33", k);
        end
        checks++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            errors++;
            $display("FAIL div_m7_2: got hi=%h lo=%h expected hi=ffffffff lo=fffffffd", hi, lo);
        end
        launch(1'b1, 32'd7, 32'hFFFF_FFFE);
        wait_done(k, nb);
        checks++;
        if ({hi, lo} !== 64'h0000_0001_FFFF_FFFD) begin
            errors++;
            $display("FAIL div_7_m2: got hi=%h lo=%h expected hi=00000001 lo=fffffffd", hi, lo);
        end
        launch(1'b1, 32'd100, 32'd7);
        wait_done(k, nb);
        checks++;
        if ({hi, lo} !== 64'h0000_0002_0000_000E) begin
            errors++;
            $display("FAIL div_100_7: got hi=%h lo=%h expected hi=00000002 lo=0000000e", hi, lo);
        end
        launch(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
        wait_done(k, nb);
        checks++;
        if ({hi, lo} !== 64'hFFFF_FFFE_0000_000E) begin
            errors++;
            $display("FAIL div_m100_m7: got hi=%h lo=%h expected hi=fffffffe lo=0000000e", hi, lo);
        end
    endtask

    task automatic test_div_zero();
        int k;
        int nb;
        launch(1'b0, 32'd7, 32'hFFFF_FFFD);
        wait_done(k, nb);
        launch(1'b1, 32'd5, 32'd0);
        checks++;
        if ({done, div_zero, busy} !== 3'b110) begin
            errors++;
            $display("FAIL divzero_flags: got done/dz/busy=%b expected 110", {done, div_zero, busy});
        end
        checks++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            errors++;
            $display("FAIL divzero_hilo_kept: got %h_%h expected ffffffff_ffffffeb", hi, lo);
        end
        @(negedge clk);
        checks++;
        if ({done, div_zero, busy} !== 3'b000) begin
            errors++;
            $display("FAIL divzero_pulse: got done/dz/busy=%b expected 000", {done, div_zero, busy});
        end
    endtask

    task automatic test_back_to_back();
        int k;
        int nb;
        launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(k, nb);
        checks++;
        if ({hi, lo, div_zero} !== {32'h0, 32'h8000_0000, 1'b0}) begin
            errors++;
            $display("FAIL div_min_m1: got hi=%h lo=%h dz=%b expected hi=0 lo=80000000 dz=0",
                     hi, lo, div_zero);
        end
        // Request in the DONE cycle itself
        start = 1'b1;
        op    = 1'b0;
        a     = 32'd3;
        b     = 32'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b expected 1", busy);
        end
        wait_done(k, nb);
        checks++;
        if (k !== 33 || {hi, lo} !== 64'h0000_0000_0000_000C) begin
            errors++;
            $display("FAIL b2b_mult_3x4: got k=%0d %h_%h expected k=33 00000000_0000000c", k, hi, lo);
        end
    endtask

    task automatic test_ignore_start();
        int k;
        int nb;
        launch(1'b0, 32'd1000, 32'hFFFF_FC18);
        k  = 0;
        nb = 0;
        while (done !== 1'b1 && k < 200) begin
            if (k == 5) begin
                start = 1'b1;
                op    = 1'b1;
                a     = 32'd9;
                b     = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        checks++;
        if (k !== 33 || {hi, lo} !== 64'hFFFF_FFFF_FFF0_BDC0) begin
            errors++;
            $display("FAIL ignore_start: got k=%0d %h_%h expected k=33 ffffffff_fff0bdc0", k, hi, lo);
        end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL ignore_not_queued: got busy/done=%b expected 00", {busy, done});
        end
    endtask

    task automatic test_reset_abort();
        int k;
        int nb;
        launch(1'b0, 32'd123, 32'd456);
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_running: got busy=%b expected 1", busy);
        end
        reset = 1'b1;
        start = 1'b1;
        op    = 1'b0;
        a     = 32'd1;
        b     = 32'd1;
        @(negedge clk);
        checks++;
        if ({hi, lo, busy, done, div_zero} !== 67'h0) begin
            errors++;
            $display("FAIL abort_outputs: got %h_%h busy/done/dz=%b expected all 0",
                     hi, lo, {busy, done, div_zero});
        end
        reset = 1'b0;
        start = 1'b1;
        op    = 1'b0;
        a     = 32'hFFFF_FFFB;
        b     = 32'd6;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_accept: got busy=%b expected 1", busy);
        end
        wait_done(k, nb);
        checks++;
        if (k !== 33 || {hi, lo} !== 64'hFFFF_FFFF_FFFF_FFE2) begin
            errors++;
            $display("FAIL restart_m5x6: got k=%0d %h_%h expected k=33 ffffffff_ffffffe2", k, hi, lo);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        test_reset();
        test_mult_basic();
        test_mult_corners();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_ignore_start();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
